// File: rtl/xor_gate_popcount.sv
// xor_gate_popcount: combinational count of set bits in a WIDTH-bit vector.
module xor_gate_popcount #(
    parameter int WIDTH = 1,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] bits_i,
    output logic [CNT_W-1:0] cnt_o
);
    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < WIDTH; i++) cnt_o = cnt_o + CNT_W'(bits_i[i]);
    end
endmodule

// File: rtl/xor_gate.sv
// xor_gate: bitwise a^b with registered copy, difference popcount and any-difference flag.
module xor_gate #(
    parameter int  WIDTH = 1,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic [CNT_W-1:0] diff_cnt,
    output logic             any_diff
);
    logic [CNT_W-1:0] diff_cnt_d, diff_cnt_q;
    logic             any_diff_q;

    assign y = a ^ b;

    xor_gate_popcount #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_popcount (
        .bits_i(y),
        .cnt_o (diff_cnt_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q        <= '0;
            diff_cnt_q <= '0;
            any_diff_q <= 1'b0;
        end else begin
            y_q        <= y;
            diff_cnt_q <= diff_cnt_d;
            any_diff_q <= |y;
        end
    end

    assign diff_cnt = diff_cnt_q;
    assign any_diff = any_diff_q;
endmodule

// File: tb/tb_xor_gate.sv
// tb_xor_gate: directed checks of xor_gate at WIDTH 1, 8 and 64.
module tb_xor_gate;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        a1, b1, y1, y1_q, cnt1, any1;
    logic [7:0]  a8, b8, y8, y8_q;
    logic [3:0]  cnt8;
    logic        any8;
    logic [63:0] a64, b64, y64, y64_q;
    logic [6:0]  cnt64;
    logic        any64;
    int          tests = 0;
    int          failed = 0;

    always #5 clk = ~clk;

    xor_gate #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1),
        .y(y1), .y_q(y1_q), .diff_cnt(cnt1), .any_diff(any1)
    );
    xor_gate #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8),
        .y(y8), .y_q(y8_q), .diff_cnt(cnt8), .any_diff(any8)
    );
    xor_gate #(.WIDTH(64)) u_w64 (
        .clk(clk), .rst_n(rst_n), .a(a64), .b(b64),
        .y(y64), .y_q(y64_q), .diff_cnt(cnt64), .any_diff(any64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] tt_in [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic       tt_y  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        rst_n = 1'b0;
        a1 = 0; b1 = 0; a8 = '0; b8 = '0; a64 = '0; b64 = '0;
        tick();
        a8 = 8'hFF;
        tick();
        check("rst_y8_q", y8_q, 0);
        check("rst_cnt8", cnt8, 0);
        check("rst_any8", any8, 0);
        check("rst_y8_comb", y8, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        a8 = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            {a1, b1} = tt_in[i];
            #1 check($sformatf("w1_y_%0d", i), y1, tt_y[i]);
            tick();
            check($sformatf("w1_yq_%0d", i), y1_q, tt_y[i]);
            check($sformatf("w1_cnt_%0d", i), cnt1, tt_y[i]);
            check($sformatf("w1_any_%0d", i), any1, tt_y[i]);
        end
        @(negedge clk);
        a8 = 8'hF0; b8 = 8'h0F;
        #1 check("w8_y_comb", y8, 8'hFF);
        tick();
        check("w8_yq_ff", y8_q, 8'hFF);
        check("w8_cnt_8", cnt8, 8);
        check("w8_any_1", any8, 1);
        @(negedge clk);
        a8 = 8'hA5; b8 = 8'hA5;
        #1 check("w8_y_eq", y8, 8'h00);
        tick();
        check("w8_yq_eq", y8_q, 0);
        check("w8_cnt_eq", cnt8, 0);
        check("w8_any_eq", any8, 0);
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h00;
        #1 check("lat_pre1", cnt8, 0);
        tick();
        check("lat_cnt1", cnt8, 1);
        @(negedge clk);
        a8 = 8'h03;
        #1 check("lat_pre2", cnt8, 1);
        tick();
        check("lat_cnt2", cnt8, 2);
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00;
        tick();
        check("ar_pre_yq", y8_q, 8'hFF);
        #2 rst_n = 1'b0;
        #1;
        check("ar_yq", y8_q, 0);
        check("ar_cnt", cnt8, 0);
        check("ar_any", any8, 0);
        check("ar_y_comb", y8, 8'hFF);
        tick();
        check("ar_hold_yq", y8_q, 0);
        check("ar_hold_cnt", cnt8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("ar_rel_yq", y8_q, 8'hFF);
        check("ar_rel_cnt", cnt8, 8);
        check("ar_rel_any", any8, 1);
        @(negedge clk);
        a64 = '1; b64 = '0;
        #1 check("w64_y_comb", y64, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        check("w64_cnt_64", cnt64, 64);
        check("w64_any_1", any64, 1);
        check("w64_yq", y64_q, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        b64 = '1;
        tick();
        check("w64_cnt_0", cnt64, 0);
        check("w64_any_0", any64, 0);
        @(negedge clk);
        a64 = 64'h8000_0000_0000_0001; b64 = 64'h0000_0000_0000_0000;
        tick();
        check("w64_cnt_2", cnt64, 2);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
